// File: rtl/cpa_share_pkg.sv
// cpa_share_pkg: shared types and helpers for the shared carry-propagate
// adder controller (cpa_share_ctrl) and its ripple slice (cpa_slice).
//   state_e     - sequencer states IDLE/LO/HI/DONE
//   W_DEFAULT   - default slice width
//   sat_value() - saturation constant for a narrow (W) or wide (2W) result;
//                 used only when CPA_SHARE_CTRL_SAT_EN is defined.
package cpa_share_pkg;

    localparam int unsigned W_DEFAULT = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Returns the two's-complement extreme for the op width: min negative when
    // neg=1, max positive otherwise. The result is 64 bits wide so the same
    // helper serves any slice width up to 32; callers size-cast it down.
    function automatic logic [63:0] sat_value(input logic neg, input logic wide,
                                              input int unsigned w);
        int unsigned msb;
        logic [63:0] top;
        msb = wide ? (2 * w - 1) : (w - 1);
        top = 64'd1 << msb;
        return neg ? top : (top - 64'd1);
    endfunction

endpackage

// File: rtl/cpa_slice.sv
// cpa_slice: combinational W-bit ripple-carry adder slice.
// Ports:
//   a_i, b_i  [W-1:0] operands
//   cin_i             carry in
//   sum_o     [W-1:0] a + b + cin modulo 2^W
//   cout_o            carry out of the MSB
//   c_msb_o           carry into the MSB (cout ^ c_msb gives signed overflow)
module cpa_slice #(
    parameter int unsigned W = 13
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         c_msb_o
);

    logic [W:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o  = c[W];
    assign c_msb_o = c[W-1];

endmodule

// File: rtl/cpa_share_ctrl.sv
// cpa_share_ctrl: time-shares one W-bit adder slice between two requesters.
// A narrow op takes one pass (LO); a wide op takes two (LO then HI), with the
// low-slice carry registered and fed into the high slice.
// Optional build macro: CPA_SHARE_CTRL_SAT_EN - saturate rsp_sum on signed
// overflow (cout/ovf still report raw values). Undefined: raw wrapped sum.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req{0,1}_valid/_ready        requester handshake (ready is combinational)
//   req{0,1}_a/_b [2W-1:0]       operands; narrow ops use [W-1:0]
//   req{0,1}_wide                1 = 2W-bit op
//   rsp_valid/rsp_ready          response handshake
//   rsp_id                       requester index of the op
//   rsp_sum [2W-1:0]             result, upper half 0 for narrow ops
//   rsp_cout, rsp_ovf            carry out / signed overflow of final slice
module cpa_share_ctrl
    import cpa_share_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [2*W-1:0] req0_a,
    input  logic [2*W-1:0] req0_b,
    input  logic           req0_wide,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [2*W-1:0] req1_a,
    input  logic [2*W-1:0] req1_b,
    input  logic           req1_wide,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_sum,
    output logic           rsp_cout,
    output logic           rsp_ovf
);

`ifdef CPA_SHARE_CTRL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e         state_q, state_d;
    logic           rr_q, rr_d;
    logic           id_q, id_d;
    logic           wide_q, wide_d;
    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] b_q, b_d;
    logic [2*W-1:0] sum_q, sum_d;
    logic           carry_lo_q, carry_lo_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic           grant;
    logic           accept;
    logic [W-1:0]   op_a, op_b, s_sum;
    logic           op_cin, s_cout, s_cmsb, s_ovf;
    logic [2*W-1:0] sat_val;

    // Arbitration: a lone valid requester wins; on contention the rr pointer
    // picks, and it flips away from each winner so neither side starves.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) grant = rr_q;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    // The single slice sees the low halves in LO and the high halves in HI.
    always_comb begin
        op_a   = a_q[W-1:0];
        op_b   = b_q[W-1:0];
        op_cin = 1'b0;
        if (state_q == HI) begin
            op_a   = a_q[2*W-1:W];
            op_b   = b_q[2*W-1:W];
            op_cin = carry_lo_q;
        end
    end

    cpa_slice #(.W(W)) u_slice (
        .a_i    (op_a),
        .b_i    (op_b),
        .cin_i  (op_cin),
        .sum_o  (s_sum),
        .cout_o (s_cout),
        .c_msb_o(s_cmsb)
    );

    assign s_ovf = s_cout ^ s_cmsb;

    // Overflow implies both operands share a sign, so the final slice's A MSB
    // chooses the direction of saturation.
    assign sat_val = (2*W)'(sat_value(op_a[W-1], state_q == HI, W));

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        wide_d     = wide_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_lo_d = carry_lo_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    wide_d  = grant ? req1_wide : req0_wide;
                    id_d    = grant;
                    rr_d    = ~grant;
                    state_d = LO;
                end
            end
            LO: begin
                sum_d[W-1:0]   = s_sum;
                sum_d[2*W-1:W] = '0;
                carry_lo_d     = s_cout;
                if (wide_q) begin
                    state_d = HI;
                end else begin
                    cout_d = s_cout;
                    ovf_d  = s_ovf;
                    if (SAT_EN && s_ovf) sum_d = sat_val;
                    state_d = DONE;
                end
            end
            HI: begin
                sum_d[2*W-1:W] = s_sum;
                cout_d         = s_cout;
                ovf_d          = s_ovf;
                if (SAT_EN && s_ovf) sum_d = sat_val;
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            id_q       <= 1'b0;
            wide_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_lo_q <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            wide_q     <= wide_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_lo_q <= carry_lo_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_cpa_share_ctrl.sv
// tb_cpa_share_ctrl: self-checking bench for cpa_share_ctrl. Expected results
// come from an arithmetic model of the add (integer sum, masked to the op
// width, sign rules for overflow); saturation is modelled when the same macro
// is defined for the bench.
module tb_cpa_share_ctrl;

    localparam int W  = 13;
    localparam int W2 = 2 * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W2-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_wide = 1'b0, req1_wide = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [W2-1:0] rsp_sum;
    logic          rsp_cout, rsp_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W2-1:0] sum;
        logic          cout;
        logic          ovf;
    } res_t;

    cpa_share_ctrl #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_wide (req0_wide),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_wide (req1_wide),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    // Reference: add as integers at the op width, then apply sign rules.
    function automatic res_t model(input logic [W2-1:0] a, input logic [W2-1:0] b,
                                   input logic wide);
        res_t r;
        longint unsigned n, mask, ma, mb, s, ss, sa, sb;
        n    = wide ? W2 : W;
        mask = (64'd1 << n) - 64'd1;
        ma   = 64'(a) & mask;
        mb   = 64'(b) & mask;
        s    = ma + mb;
        sa   = (ma >> (n - 1)) & 64'd1;
        sb   = (mb >> (n - 1)) & 64'd1;
        ss   = (s >> (n - 1)) & 64'd1;
        r.sum  = W2'(s & mask);
        r.cout = ((s >> n) & 64'd1) != 0;
        r.ovf  = (sa == sb) && (ss != sa);
`ifdef CPA_SHARE_CTRL_SAT_EN
        if (r.ovf) r.sum = (sa != 0) ? W2'(64'd1 << (n - 1)) : W2'((64'd1 << (n - 1)) - 64'd1);
`endif
        return r;
    endfunction

    // Present an op on requester n and return just after its accept edge.
    task automatic send(input bit n, input logic [W2-1:0] a, input logic [W2-1:0] b,
                        input logic wide, output bit tmo);
        int k;
        tmo = 1'b0;
        if (n) begin req1_valid = 1; req1_a = a; req1_b = b; req1_wide = wide; end
        else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_wide = wide; end
        #1;
        k = 0;
        while (!(n ? req1_ready : req0_ready) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!(n ? req1_ready : req0_ready)) tmo = 1'b1;
        else begin @(posedge clk); #1; end
        if (n) req1_valid = 0; else req0_valid = 0;
    endtask

    // Count edges since the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat, output bit tmo);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        tmo = !rsp_valid;
    endtask

    task automatic issue(input bit n, input logic [W2-1:0] a, input logic [W2-1:0] b,
                         input logic wide, input int hold, output int lat,
                         output logic id, output res_t obs, output bit tmo);
        bit t1, t2;
        rsp_ready = (hold == 0);
        send(n, a, b, wide, t1);
        lat = 0;
        t2 = 1'b0;
        if (!t1) wait_rsp(lat, t2);
        id       = rsp_id;
        obs.sum  = rsp_sum;
        obs.cout = rsp_cout;
        obs.ovf  = rsp_ovf;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tmo = t1 || t2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b id=%b sum=%h c=%b o=%b exp all 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
        end
        reset = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_rr_grant got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_single_grant got r0=%b r1=%b exp r0=0 r1=1", req0_ready, req1_ready);
        end
        req1_valid = 0;
    endtask

    task automatic test_directed();
        logic [W2-1:0] va[4]   = '{26'h0000FFF, 26'h0001FFF, 26'h3FFFFFF, 26'h0001000};
        logic [W2-1:0] vb[4]   = '{26'h0000001, 26'h0000001, 26'h0000001, 26'h0001FFF};
        logic          vw[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit            vn[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        int lat; logic id; res_t obs, exp_r; bit tmo;
        for (int i = 0; i < 4; i++) begin
            exp_r = model(va[i], vb[i], vw[i]);
            issue(vn[i], va[i], vb[i], vw[i], 0, lat, id, obs, tmo);
            checks++;
            if (tmo || lat !== (vw[i] ? 3 : 2)) begin
                errors++;
                $display("FAIL dir_latency[%0d] got %0d (timeout=%0b) exp %0d", i, lat, tmo, vw[i] ? 3 : 2);
            end
            checks++;
            if (id !== vn[i]) begin
                errors++;
                $display("FAIL dir_id[%0d] got %b exp %b", i, id, vn[i]);
            end
            checks++;
            if (obs !== exp_r) begin
                errors++;
                $display("FAIL dir_result[%0d] got sum=%h c=%b o=%b exp sum=%h c=%b o=%b",
                         i, obs.sum, obs.cout, obs.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
            end
        end
    endtask

    task automatic test_random();
        int lat, hold; logic id; res_t obs, exp_r; bit tmo, n;
        logic [W2-1:0] a, b; logic wide;
        for (int i = 0; i < 30; i++) begin
            n    = 1'($urandom_range(0, 1));
            wide = 1'($urandom_range(0, 1));
            a    = W2'($urandom);
            b    = W2'($urandom);
            if ($urandom_range(0, 3) == 0) a[W-1:0] = 13'h0FFF;
            if ($urandom_range(0, 3) == 0) b = '1;
            hold = $urandom_range(0, 3);
            exp_r = model(a, b, wide);
            issue(n, a, b, wide, hold, lat, id, obs, tmo);
            checks++;
            if (tmo || lat !== (wide ? 3 : 2) || id !== n || obs !== exp_r) begin
                errors++;
                $display("FAIL rand[%0d] got lat=%0d id=%b sum=%h c=%b o=%b exp lat=%0d id=%b sum=%h c=%b o=%b",
                         i, lat, id, obs.sum, obs.cout, obs.ovf, wide ? 3 : 2, n,
                         exp_r.sum, exp_r.cout, exp_r.ovf);
            end
        end
    endtask

    task automatic test_arbitration();
        int k, lat; bit g, tmo; res_t exp_r, obs;
        int cnt[2] = '{0, 0};
        do_reset();
        rsp_ready = 1'b1;
        req0_a = W2'($urandom); req0_b = W2'($urandom); req0_wide = 1'($urandom);
        req1_a = W2'($urandom); req1_b = W2'($urandom); req1_wide = 1'($urandom);
        req0_valid = 1; req1_valid = 1;
        #1;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (!(req0_ready || req1_ready) && k < 20) begin @(posedge clk); #1; k++; end
            checks++;
            if ((req0_ready ^ req1_ready) !== 1'b1 || req1_ready !== 1'(i % 2)) begin
                errors++;
                $display("FAIL arb_grant[%0d] got r0=%b r1=%b exp r%0d only", i, req0_ready, req1_ready, i % 2);
            end
            g = req1_ready;
            exp_r = g ? model(req1_a, req1_b, req1_wide) : model(req0_a, req0_b, req0_wide);
            @(posedge clk); #1;
            if (g) begin req1_a = W2'($urandom); req1_b = W2'($urandom); req1_wide = 1'($urandom); end
            else   begin req0_a = W2'($urandom); req0_b = W2'($urandom); req0_wide = 1'($urandom); end
            wait_rsp(lat, tmo);
            obs.sum = rsp_sum; obs.cout = rsp_cout; obs.ovf = rsp_ovf;
            checks++;
            if (tmo || rsp_id !== g || obs !== exp_r) begin
                errors++;
                $display("FAIL arb_rsp[%0d] got id=%b sum=%h c=%b o=%b exp id=%b sum=%h c=%b o=%b",
                         i, rsp_id, obs.sum, obs.cout, obs.ovf, g, exp_r.sum, exp_r.cout, exp_r.ovf);
            end
            if (!tmo) cnt[rsp_id]++;
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (cnt[0] !== 4 || cnt[1] !== 4) begin
            errors++;
            $display("FAIL arb_fairness got %0d/%0d exp 4/4", cnt[0], cnt[1]);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit tmo, bad_stable, bad_ready;
        res_t exp_r;
        logic [W2-1:0] a = 26'h2AAAAAA, b = 26'h1555556;
        exp_r = model(a, b, 1'b1);
        rsp_ready = 1'b0;
        send(1'b1, a, b, 1'b1, tmo);
        if (!tmo) wait_rsp(lat, tmo);
        req0_valid = 1; req1_valid = 1;
        bad_stable = 0; bad_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!rsp_valid || rsp_id !== 1'b1 || {rsp_sum, rsp_cout, rsp_ovf} !== exp_r) bad_stable = 1;
            if (req0_ready || req1_ready) bad_ready = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (tmo || bad_stable) begin
            errors++;
            $display("FAIL bp_hold got v=%b id=%b sum=%h c=%b o=%b exp v=1 id=1 sum=%h c=%b o=%b",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
        end
        checks++;
        if (bad_ready) begin
            errors++;
            $display("FAIL bp_ready got ready asserted while busy exp none");
        end
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rsp_valid=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_reset_in_hi();
        bit tmo, seen;
        send(1'b1, 26'h0123456, 26'h0FEDCBA, 1'b1, tmo);
        @(posedge clk); #1;           // now in HI
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tmo || {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== '0) begin
            errors++;
            $display("FAIL rst_hi_outputs got v=%b id=%b sum=%h c=%b o=%b exp all 0 (timeout=%0b)",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, tmo);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_hi_idle got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_hi_no_rsp got a response after reset exp none");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_arbitration();
        test_backpressure();
        test_reset_in_hi();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
